// File: rtl/pa_inst_sched_if.sv
// Requester and array-controller side signals of the instruction scheduler.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface pa_inst_sched_if #(
    parameter int NREQ   = 2,
    parameter int INST_W = 16
);
    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0][INST_W-1:0]  req_inst;
    logic [NREQ-1:0]              req_ready;
    logic                         load;
    logic [INST_W-1:0]            oinst;
    logic                         next;

    modport master (
        output req_valid, req_inst, next,
        input  req_ready, load, oinst
    );

    modport slave (
        input  req_valid, req_inst, next,
        output req_ready, load, oinst
    );
endinterface

// File: rtl/pa_inst_sched.sv
// Round-robin instruction scheduler: arbitrates requesters into a FIFO and issues
// non-NOP instructions to the array controller with the load/next overlap handshake.
module pa_inst_sched #(
    parameter int NREQ   = 2,
    parameter int DEPTH  = 4,
    parameter int OPC_W  = 4,
    parameter int LAP_N  = 8,
    parameter int INST_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    pa_inst_sched_if.slave           sched_if,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     idle_o,
    output logic [15:0]              issued_cnt_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int RW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SCW = LAP_N + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [SCW-1:0]          sc_q, sc_d, sc_dec_s;
    logic [AW-1:0]           rd_ptr_q, wr_ptr_q;
    logic [AW:0]             count_q, count_d;
    logic [RW-1:0]           rr_q, gidx_s, cand_s;
    logic [INST_W-1:0]       mem_q [DEPTH];
    logic [INST_W-1:0]       oinst_q, head_s;
    logic                    load_q, idle_q;
    logic [15:0]             issued_q;
    logic [NREQ-1:0]         grant_s;
    logic                    found_s, can_push_s, full_s, head_vld_s;
    logic                    pop_s, latch_s, take_s;

    function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end else begin
            s = s;
        end
        return RW'(s);
    endfunction

    assign head_s     = mem_q[rd_ptr_q];
    assign head_vld_s = (count_q != {(AW+1){1'b0}});
    assign full_s     = (count_q == (AW+1)'(DEPTH));
    // A full FIFO may still accept when the dispatcher pops in the same cycle.
    assign can_push_s = !reset && (!full_s || pop_s);

    // Round-robin grant search starting at the pointer.
    always_comb begin
        grant_s = {NREQ{1'b0}};
        gidx_s  = {RW{1'b0}};
        found_s = 1'b0;
        cand_s  = {RW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = wrap_add(rr_q, k);
            if (!found_s && sched_if.req_valid[cand_s] && can_push_s) begin
                found_s         = 1'b1;
                gidx_s          = cand_s;
                grant_s[cand_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Dispatcher next state, shadow counter and head pop/latch decisions.
    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        pop_s    = 1'b0;
        latch_s  = 1'b0;
        take_s   = 1'b0;
        sc_dec_s = (sc_q == {SCW{1'b0}}) ? {SCW{1'b0}} : (sc_q - SCW'(1));
        case (state_q)
            ST_IDLE: take_s = 1'b1;
            ST_ISSUE: begin
                sc_d    = {1'b0, oinst_q[LAP_N-1:0]} + SCW'(2);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                sc_d = sc_dec_s;
                if (sched_if.next || (sc_dec_s == {SCW{1'b0}})) begin
                    take_s = 1'b1;
                end else begin
                    take_s = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (take_s) begin
            if (head_vld_s) begin
                pop_s = 1'b1;
                if (head_s[INST_W-1 -: OPC_W] == {OPC_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    latch_s = 1'b1;
                    state_d = ST_ISSUE;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = state_d;
        end
    end

    // Occupancy update from push/pop.
    always_comb begin
        case ({found_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because the count gates the head.
    always_ff @(posedge clk) begin
        if (found_s) begin
            mem_q[wr_ptr_q] <= sched_if.req_inst[gidx_s];
        end
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sc_q     <= {SCW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            rr_q     <= {RW{1'b0}};
            oinst_q  <= {INST_W{1'b0}};
            load_q   <= 1'b0;
            idle_q   <= 1'b1;
            issued_q <= 16'd0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            count_q <= count_d;
            load_q  <= (state_d == ST_ISSUE);
            idle_q  <= (count_d == {(AW+1){1'b0}}) && (state_d == ST_IDLE);
            if (state_d == ST_ISSUE) begin
                issued_q <= issued_q + 16'd1;
            end
            if (found_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                rr_q     <= wrap_add(gidx_s, 1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (latch_s) begin
                oinst_q <= head_s;
            end
        end
    end

    assign sched_if.req_ready = grant_s;
    assign sched_if.load      = load_q;
    assign sched_if.oinst     = oinst_q;
    assign fifo_count_o       = count_q;
    assign idle_o             = idle_q;
    assign issued_cnt_o       = issued_q;
endmodule

// File: tb/tb_pa_inst_sched.sv
// Self-checking bench for pa_inst_sched: scenario tasks plus a scoreboard that
// records accepted non-NOP instructions and checks them against each load.
module tb_pa_inst_sched;
    localparam int NREQ  = 2;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [2:0]  fifo_count;
    logic        idle;
    logic [15:0] issued_cnt;

    pa_inst_sched_if #(.NREQ(NREQ), .INST_W(16)) bus ();

    pa_inst_sched #(
        .NREQ(NREQ), .DEPTH(DEPTH), .OPC_W(4), .LAP_N(8), .INST_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sched_if(bus),
        .fifo_count_o(fifo_count),
        .idle_o(idle),
        .issued_cnt_o(issued_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_inst;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mk(input int op, input int arg, input int vs);
        logic [31:0] o, a, v;
        o = op; a = arg; v = vs;
        return {o[3:0], a[3:0], v[7:0]};
    endfunction

    // Scoreboard: record accepted instructions, compare each issue in order.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i] && (bus.req_inst[i][15:12] != 4'd0))
                    exp_q.push_back(bus.req_inst[i]);
            end
            n_assert++;
            if ($countones(bus.req_ready) > 1) begin
                n_fail++;
                $display("FAIL grant_onehot: req_ready=%b, required at most one bit set", bus.req_ready);
            end
            if (bus.load) begin
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL load_unexpected: oinst=%h at cycle %0d, required no load", bus.oinst, cyc);
                end else begin
                    exp_inst = exp_q.pop_front();
                    if (bus.oinst !== exp_inst) begin
                        n_fail++;
                        $display("FAIL oinst_order: got %h required %h", bus.oinst, exp_inst);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_inst  = '0;
        bus.next      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_one(input int r, input logic [15:0] inst, output int tc);
        bus.req_inst[r]  = inst;
        bus.req_valid[r] = 1'b1;
        tc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.req_ready[r]) begin
                tc = cyc;
                break;
            end
        end
        n_assert++;
        if (tc < 0) begin
            n_fail++;
            $display("FAIL push_timeout: requester %0d never granted, required a grant", r);
        end
        @(posedge clk);
        #1;
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic wait_load(input int budget, output int lc);
        lc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.load) begin
                lc = cyc;
                break;
            end
        end
        n_assert++;
        if (lc < 0) begin
            n_fail++;
            $display("FAIL load_timeout: no load within %0d cycles, required one", budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_inst  = {mk(1, 0, 8), mk(1, 1, 8)};
        bus.next      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_assert += 6;
        if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b required 00", bus.req_ready); end
        if (bus.load !== 1'b0)       begin n_fail++; $display("FAIL rst_load: got %b required 0", bus.load); end
        if (bus.oinst !== 16'h0000)  begin n_fail++; $display("FAIL rst_oinst: got %h required 0000", bus.oinst); end
        if (fifo_count !== 3'd0)     begin n_fail++; $display("FAIL rst_count: got %0d required 0", fifo_count); end
        if (idle !== 1'b1)           begin n_fail++; $display("FAIL rst_idle: got %b required 1", idle); end
        if (issued_cnt !== 16'd0)    begin n_fail++; $display("FAIL rst_issued: got %0d required 0", issued_cnt); end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        int t, lc;
        apply_reset();
        push_one(0, mk(1, 5, 8), t);
        wait_load(20, lc);
        n_assert++;
        if (lc != t + 2) begin n_fail++; $display("FAIL single_latency: load at %0d required %0d", lc, t + 2); end
        repeat (4) @(posedge clk);
        #1;
        bus.next = 1'b1;
        @(negedge clk);
        n_assert++;
        if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy: idle got %b required 0", idle); end
        @(posedge clk);
        #1;
        bus.next = 1'b0;
        @(negedge clk);
        n_assert += 3;
        if (idle !== 1'b1)         begin n_fail++; $display("FAIL single_idle: got %b required 1", idle); end
        if (issued_cnt !== 16'd1)  begin n_fail++; $display("FAIL single_issued: got %0d required 1", issued_cnt); end
        if (fifo_count !== 3'd0)   begin n_fail++; $display("FAIL single_count: got %0d required 0", fifo_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_arbitration();
        int cnt[2];
        int total, loads;
        bit pend;
        logic [1:0] expg;
        apply_reset();
        cnt = '{0, 0}; total = 0; loads = 0; pend = 1'b0;
        for (int c = 0; c < 400 && loads < 8; c++) begin
            for (int r = 0; r < 2; r++) begin
                bus.req_valid[r] = (cnt[r] < 4);
                bus.req_inst[r]  = mk(2, r * 4 + cnt[r], 10);
            end
            @(negedge clk);
            if (pend) begin
                n_assert++;
                if (!bus.load) begin n_fail++; $display("FAIL full_grant: grant while full without pop, load got 0 required 1"); end
            end
            pend = (fifo_count == 3'd4) && (bus.req_ready != 2'b00);
            if (bus.load) loads++;
            if (bus.req_ready != 2'b00) begin
                expg = 2'(1 << (total % 2));
                n_assert++;
                if (bus.req_ready !== expg) begin n_fail++; $display("FAIL grant_order: got %b required %b", bus.req_ready, expg); end
                total++;
                cnt[bus.req_ready[1] ? 1 : 0]++;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        @(negedge clk);
        n_assert += 4;
        if (total != 8)            begin n_fail++; $display("FAIL arb_grants: got %0d required 8", total); end
        if (loads != 8)            begin n_fail++; $display("FAIL arb_loads: got %0d required 8", loads); end
        if (issued_cnt !== 16'd8)  begin n_fail++; $display("FAIL arb_issued: got %0d required 8", issued_cnt); end
        if (exp_q.size() != 0)     begin n_fail++; $display("FAIL arb_leftover: got %0d required 0", exp_q.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int pushed, loads, next_at, last_next;
        apply_reset();
        pushed = 0; loads = 0; next_at = -1; last_next = -100;
        for (int c = 0; c < 200 && loads < 3; c++) begin
            bus.req_valid[0] = (pushed < 3);
            bus.req_inst[0]  = mk(3, pushed, 16);
            bus.next         = (cyc == next_at);
            @(negedge clk);
            if (bus.req_ready[0]) pushed++;
            if (bus.next) last_next = cyc;
            if (bus.load) begin
                if (loads > 0) begin
                    n_assert++;
                    if (cyc != last_next + 1) begin n_fail++; $display("FAIL b2b_timing: load at %0d required %0d", cyc, last_next + 1); end
                end
                loads++;
                next_at = cyc + 13;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        bus.next      = 1'b0;
        @(negedge clk);
        n_assert += 2;
        if (loads != 3)           begin n_fail++; $display("FAIL b2b_loads: got %0d required 3", loads); end
        if (issued_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_issued: got %0d required 3", issued_cnt); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_short();
        int vs_tab[4];
        int lcs[$];
        int pushed;
        vs_tab = '{0, 1, 2, 0};
        apply_reset();
        pushed = 0;
        for (int c = 0; c < 80 && lcs.size() < 4; c++) begin
            bus.req_valid[0] = (pushed < 4);
            bus.req_inst[0]  = mk(4, pushed, vs_tab[(pushed < 4) ? pushed : 0]);
            @(negedge clk);
            if (bus.req_ready[0]) pushed++;
            if (bus.load) lcs.push_back(cyc);
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        n_assert++;
        if (lcs.size() != 4) begin
            n_fail++;
            $display("FAIL short_loads: got %0d required 4", lcs.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_assert++;
                if (lcs[i] - lcs[i-1] != i + 2) begin
                    n_fail++;
                    $display("FAIL short_gap%0d: got %0d required %0d", i, lcs[i] - lcs[i-1], i + 2);
                end
            end
        end
    endtask

    task automatic test_nop();
        int op_tab[6];
        int pushed, loads, t_a, first_load;
        op_tab = '{0, 5, 0, 0, 6, 0};
        apply_reset();
        pushed = 0; loads = 0; t_a = -1; first_load = -1;
        for (int c = 0; c < 40; c++) begin
            bus.req_valid[0] = (pushed < 6);
            bus.req_inst[0]  = mk(op_tab[(pushed < 6) ? pushed : 0], pushed, 0);
            @(negedge clk);
            if (bus.req_ready[0]) begin
                if (pushed == 1) t_a = cyc;
                pushed++;
            end
            if (bus.load) begin
                if (loads == 0) first_load = cyc;
                loads++;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        @(negedge clk);
        n_assert += 6;
        if (loads != 2)              begin n_fail++; $display("FAIL nop_loads: got %0d required 2", loads); end
        if (first_load != t_a + 2)   begin n_fail++; $display("FAIL nop_latency: load at %0d required %0d", first_load, t_a + 2); end
        if (issued_cnt !== 16'd2)    begin n_fail++; $display("FAIL nop_issued: got %0d required 2", issued_cnt); end
        if (fifo_count !== 3'd0)     begin n_fail++; $display("FAIL nop_count: got %0d required 0", fifo_count); end
        if (idle !== 1'b1)           begin n_fail++; $display("FAIL nop_idle: got %b required 1", idle); end
        if (exp_q.size() != 0)       begin n_fail++; $display("FAIL nop_leftover: got %0d required 0", exp_q.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_wait();
        int pushed, loads, t, lc;
        apply_reset();
        pushed = 0; loads = 0;
        for (int c = 0; c < 20 && !(pushed == 4 && loads == 1); c++) begin
            bus.req_valid[0] = (pushed < 4);
            bus.req_inst[0]  = mk(6, pushed, 40);
            @(negedge clk);
            if (bus.req_ready[0]) pushed++;
            if (bus.load) loads++;
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        @(negedge clk);
        n_assert++;
        if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL rw_queued: got %0d required 3", fifo_count); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        n_assert++;
        if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rw_ready: got %b required 00", bus.req_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        n_assert += 4;
        if (fifo_count !== 3'd0)   begin n_fail++; $display("FAIL rw_count: got %0d required 0", fifo_count); end
        if (bus.load !== 1'b0)     begin n_fail++; $display("FAIL rw_load: got %b required 0", bus.load); end
        if (idle !== 1'b1)         begin n_fail++; $display("FAIL rw_idle: got %b required 1", idle); end
        if (issued_cnt !== 16'd0)  begin n_fail++; $display("FAIL rw_issued: got %0d required 0", issued_cnt); end
        @(posedge clk);
        #1;
        push_one(1, mk(7, 1, 4), t);
        wait_load(20, lc);
        n_assert++;
        if (lc != t + 2) begin n_fail++; $display("FAIL rw_reissue: load at %0d required %0d", lc, t + 2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_back_to_back();
        test_short();
        test_nop();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pa_inst_sched.md
# pa_inst_sched

Instruction scheduler in front of the array instruction controller. It accepts processor-array instructions from NREQ requesters through round-robin arbitration and buffers them in a DEPTH-entry FIFO. It dispatches them one at a time to the array controller using that controller's load/next handshake, so a new vector operation overlaps the tail of the previous one. NOP instructions (opcode 0) are discarded without being issued.

## Interface
- NREQ, 2, number of instruction requesters (2..4)
- DEPTH, 4, instruction FIFO depth (power of two, ≥2)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  requester i holds an instruction
- req_inst  in  NREQ x pa_inst_t  instruction per requester
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- load  out  1  one-cycle issue strobe to the array controller
- oinst  out  pa_inst_t  instruction presented with load; held until the next issue
- next  in  1  array-controller pulse: current vector has 3 cycles left
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries
- idle  out  1  FIFO empty and dispatcher in IDLE
- issued_cnt  out  16  count of issued instructions; wraps at 2^16

## Operation
- Arbiter: round-robin over req_valid. The pointer starts at requester 0 after reset and moves to the requester after the granted one. req_ready is combinational from req_valid, the pointer and FIFO space, and at most one bit is high. There is no grant when the FIFO is full, except when a pop happens in the same cycle (see the simultaneous push/pop rule below).
- FIFO: a push writes req_inst of the granted requester. Read and write pointers wrap modulo DEPTH. fifo_count = writes − pops. A simultaneous push and pop leaves the count unchanged and is legal when the FIFO is full.
- Dispatcher FSM with states IDLE, ISSUE, WAIT:
  - IDLE: if the FIFO head is valid with opcode 0, pop it without issuing and stay in IDLE. If the head is valid with opcode ≠ 0, pop it, latch it into oinst, and go to ISSUE.
  - ISSUE: load=1 for exactly this cycle. Load shadow counter sc = oinst.vsize[LAP_N-1:0] + 2 (LAP_N+1 bits, no overflow). Go to WAIT.
  - WAIT: sc decrements by 1 per cycle and saturates at 0. Leave WAIT when next=1 or sc==0. The head is then handled exactly as in IDLE; if nothing is issuable, go to IDLE.
  - The sc path covers vectors too short for the controller to ever pulse next (vsize<3).
- issued_cnt increments on every load cycle. NOP drops do not count.
- next received outside WAIT is ignored.
- reset: FIFO is flushed, pointers go to 0, FSM goes to IDLE, sc=0. Any in-flight instruction is abandoned; no completion or flush is attempted.

## Timing
- Reset values: load=0, oinst=0 (opcode NOP), req_ready=0 during reset, fifo_count=0, idle=1, issued_cnt=0.
- Push in cycle t makes the entry visible at the head in cycle t+1.
- From IDLE with an empty FIFO, a push in cycle t gives load=1 in cycle t+2.
- Back-to-back issue: next in cycle t with a valid head gives load in cycle t+1. That is 2 cycles before the previous vector's last read cycle.
- The minimum gap between load pulses is 3 cycles (vsize=0: ISSUE, WAIT with sc 2→1, WAIT with sc 1→0, exit).
- A dropped NOP costs one cycle in IDLE/exit with no load.
- oinst changes only in the cycle before load. It is stable for the whole time the dispatcher is in ISSUE and WAIT.
- idle is registered. It deasserts the cycle after the first push.

## Test plan
- Single instruction, vsize=8, opcode=1, requester 0 from idle: load in cycle t+2 with oinst matching the request. Drive next 5 cycles later; FSM returns to IDLE; idle=1 in the following cycle; issued_cnt=1.
- Two requesters valid continuously with 4 instructions each, DEPTH=4: grants alternate 0,1,0,1. No grant while fifo_count=4 without a pop. Issue order matches push order. issued_cnt=8.
- Back-to-back vsize=16 instructions with next pulsed by a model controller: each load is exactly 1 cycle after next, and no load occurs while sc>0 and no next has arrived.
- Short vectors vsize=0,1,2 with next never asserted: load pulses are spaced 3, 4 and 5 cycles apart respectively.
- Interleave opcode 0 entries between valid ones: NOPs are popped with no load, and issued_cnt counts only non-NOP instructions.
- Assert reset in WAIT with 3 entries queued: the next cycle shows fifo_count=0, load=0, idle=1 and issued_cnt=0. A new push after reset issues normally at t+2.
